// File: rtl/data_memory_bank.sv
// -----------------------------------------------------------------------------
// data_memory_bank
//
// Parametrised single-port, word-addressed data memory for the Kabeta data
// path. Requests use a valid/ready handshake. Writes carry per-byte lane
// enables. Reads return after READ_LATENCY cycles, where READ_LATENCY is 1
// (RAM output register direct) or 2 (extra output register). Out-of-range
// accesses produce an error response. An optional zero-fill sweep runs after
// reset is released.
//
// Ports
//   Clock       in   rising-edge clock
//   Reset_N     in   asynchronous active-low reset
//   Req_Valid   in   request present
//   Req_Ready   out  request accepted this cycle when Req_Valid is high
//   Req_Write   in   1 = write, 0 = read
//   Req_Addr    in   word address (ADDR_WIDTH bits)
//   Req_ByteEn  in   write byte lanes, lane i covers bits 8i+7:8i
//   Req_Data    in   write data
//   Rsp_Valid   out  one-cycle response strobe
//   Rsp_Data    out  read data (zero for error responses), held between strobes
//   Rsp_Err     out  address out of range, held between strobes
// -----------------------------------------------------------------------------
module data_memory_bank #(
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH_WORDS    = 4096,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      Clock,
  input  logic                      Reset_N,
  input  logic                      Req_Valid,
  output logic                      Req_Ready,
  input  logic                      Req_Write,
  input  logic [ADDR_WIDTH-1:0]     Req_Addr,
  input  logic [DATA_WIDTH/8-1:0]   Req_ByteEn,
  input  logic [DATA_WIDTH-1:0]     Req_Data,
  output logic                      Rsp_Valid,
  output logic [DATA_WIDTH-1:0]     Rsp_Data,
  output logic                      Rsp_Err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(DEPTH_WORDS);

  localparam logic [IW-1:0]         LAST_IDX  = IW'(DEPTH_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH_WORDS);

  // Elaboration-time parameter legality checks.
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("data_memory_bank: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("data_memory_bank: DATA_WIDTH must be a positive multiple of 8");
  end
  if (DEPTH_WORDS < 2 || IW > ADDR_WIDTH) begin : g_bad_depth
    $error("data_memory_bank: DEPTH_WORDS must lie in 2..2^ADDR_WIDTH");
  end

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t          state_q, state_d;
  logic [IW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            clr_we;

  // ---------------------------------------------------------------------------
  // Control FSM: zero-fill sweep, then run forever.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    Req_Ready = 1'b0;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      ST_RUN: begin
        Req_Ready = 1'b1;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p0: request decode and RAM port steering.
  // ---------------------------------------------------------------------------
  logic            acc_p0;
  logic            in_range_p0;
  logic [IW-1:0]   idx_p0;
  logic            wr_hit_p0;
  logic            rd_hit_p0;
  logic            rsp_gen_p0;

  // Upper address bits only feed the range check; the index is the low IW bits.
  assign acc_p0      = Req_Valid && Req_Ready;
  assign in_range_p0 = ({1'b0, Req_Addr} < DEPTH_EXT);
  assign idx_p0      = Req_Addr[IW-1:0];
  assign wr_hit_p0   = acc_p0 && Req_Write && in_range_p0;
  assign rd_hit_p0   = acc_p0 && !Req_Write && in_range_p0;
  // Every accepted request except an in-range write produces a response.
  assign rsp_gen_p0  = acc_p0 && !(Req_Write && in_range_p0);

  logic                  ram_we;
  logic                  ram_re;
  logic [NB-1:0]         ram_be;
  logic [IW-1:0]         ram_widx;
  logic [DATA_WIDTH-1:0] ram_wdata;

  // The sweep owns the write port while clearing; no request can be accepted
  // then, so the two write sources never collide. Reset_N gates the port so a
  // held reset never disturbs memory contents.
  assign ram_we    = Reset_N && (clr_we || wr_hit_p0);
  assign ram_re    = Reset_N && rd_hit_p0;
  assign ram_be    = clr_we ? {NB{1'b1}} : Req_ByteEn;
  assign ram_widx  = clr_we ? clr_cnt_q : idx_p0;
  assign ram_wdata = clr_we ? '0 : Req_Data;

  // ---------------------------------------------------------------------------
  // RAM array: synchronous read, byte-lane write, no reset.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] ram_rd_q;

  always_ff @(posedge Clock) begin
    if (ram_we) begin
      for (int b = 0; b < NB; b++) begin
        if (ram_be[b]) begin
          mem_q[ram_widx][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
    if (ram_re) begin
      ram_rd_q <= mem_q[idx_p0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: response control alongside the RAM output register.
  // ---------------------------------------------------------------------------
  logic                  vld_p1_q;
  logic                  err_p1_q;
  logic                  zero_p1_q;
  logic [DATA_WIDTH-1:0] data_p1;

  // zero_p1_q masks the RAM output for error responses and right after reset,
  // so the (unreset) RAM register never leaks onto Rsp_Data in those cases.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      vld_p1_q  <= 1'b0;
      err_p1_q  <= 1'b0;
      zero_p1_q <= 1'b1;
    end else begin
      vld_p1_q <= rsp_gen_p0;
      if (rsp_gen_p0) begin
        err_p1_q  <= !in_range_p0;
        zero_p1_q <= !in_range_p0;
      end
    end
  end

  assign data_p1 = zero_p1_q ? '0 : ram_rd_q;

  // ---------------------------------------------------------------------------
  // Stage p2: optional output register outside the RAM array.
  // ---------------------------------------------------------------------------
  if (READ_LATENCY == 2) begin : g_lat2
    logic                  vld_p2_q;
    logic                  err_p2_q;
    logic [DATA_WIDTH-1:0] data_p2_q;

    always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
        vld_p2_q  <= 1'b0;
        err_p2_q  <= 1'b0;
        data_p2_q <= '0;
      end else begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          err_p2_q  <= err_p1_q;
          data_p2_q <= data_p1;
        end
      end
    end

    assign Rsp_Valid = vld_p2_q;
    assign Rsp_Err   = err_p2_q;
    assign Rsp_Data  = data_p2_q;
  end else begin : g_lat1
    assign Rsp_Valid = vld_p1_q;
    assign Rsp_Err   = err_p1_q;
    assign Rsp_Data  = data_p1;
  end

endmodule

// File: tb/tb_data_memory_bank.sv
// -----------------------------------------------------------------------------
// Testbench for data_memory_bank. Two instances share one request stream:
//   A: DEPTH_WORDS=16, READ_LATENCY=1, CLEAR_ON_RESET=1
//   B: DEPTH_WORDS=16, READ_LATENCY=2, CLEAR_ON_RESET=0
// A reference model (word array, byte-known masks, clear countdown and a
// table of expected responses keyed by cycle) predicts Req_Ready, Rsp_Valid,
// Rsp_Err and Rsp_Data for every cycle of each instance.
// -----------------------------------------------------------------------------
module tb_data_memory_bank;

  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [NB-1:0] req_be;
  logic [DW-1:0] req_data;

  logic          rdy   [2];
  logic          rv    [2];
  logic          rerr  [2];
  logic [DW-1:0] rdat  [2];

  data_memory_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) dut_a (
    .Clock(clk), .Reset_N(rst_n),
    .Req_Valid(req_valid), .Req_Ready(rdy[0]), .Req_Write(req_write),
    .Req_Addr(req_addr), .Req_ByteEn(req_be), .Req_Data(req_data),
    .Rsp_Valid(rv[0]), .Rsp_Data(rdat[0]), .Rsp_Err(rerr[0])
  );

  data_memory_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH),
    .READ_LATENCY(2), .CLEAR_ON_RESET(0)
  ) dut_b (
    .Clock(clk), .Reset_N(rst_n),
    .Req_Valid(req_valid), .Req_Ready(rdy[1]), .Req_Write(req_write),
    .Req_Addr(req_addr), .Req_ByteEn(req_be), .Req_Data(req_data),
    .Rsp_Valid(rv[1]), .Rsp_Data(rdat[1]), .Rsp_Err(rerr[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m  [2][DEPTH];
  logic [3:0]  kn_m   [2][DEPTH];   // which bytes of each word are known
  int          clr_left [2];        // sweep edges still to go
  bit          sv [2][8];           // expected response at cycle slot
  bit          se [2][8];
  logic [31:0] sd [2][8];
  logic [3:0]  sm [2][8];
  logic [31:0] last_d [2];
  logic        last_e [2];
  logic [3:0]  last_m [2];
  int          cyc = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic string nm(input int k);
    return (k == 0) ? "A" : "B";
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      clr_left[k] = (k == 0) ? DEPTH : 0;
      for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
      last_d[k] = 32'h0;
      last_e[k] = 1'b0;
      last_m[k] = 4'hF;
    end
  endtask

  task automatic model_accept(input int k, input logic w, input logic [AW-1:0] a,
                              input logic [3:0] be, input logic [31:0] d);
    bit inr;
    int slot;
    inr = (a < AW'(DEPTH));
    if (w && inr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_m[k][a[3:0]][8*b +: 8] = d[8*b +: 8];
          kn_m[k][a[3:0]][b] = 1'b1;
        end
      end
    end else begin
      slot = (cyc + lat_of(k)) % 8;
      sv[k][slot] = 1'b1;
      se[k][slot] = !inr;
      if (inr && !w) begin
        sd[k][slot] = mem_m[k][a[3:0]];
        sm[k][slot] = kn_m[k][a[3:0]];
      end else begin
        sd[k][slot] = 32'h0;
        sm[k][slot] = 4'hF;
      end
    end
  endtask

  task automatic check_cycle();
    int slot;
    slot = cyc % 8;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s ready @%0d", nm(k), cyc), {31'b0, rdy[k]},
            {31'b0, (clr_left[k] == 0)});
      if (sv[k][slot]) begin
        check($sformatf("%s rsp_valid @%0d", nm(k), cyc), {31'b0, rv[k]}, 32'd1);
        last_d[k] = sd[k][slot];
        last_e[k] = se[k][slot];
        last_m[k] = sm[k][slot];
        sv[k][slot] = 1'b0;
      end else begin
        check($sformatf("%s rsp_valid idle @%0d", nm(k), cyc), {31'b0, rv[k]}, 32'd0);
      end
      check($sformatf("%s rsp_err @%0d", nm(k), cyc), {31'b0, rerr[k]}, {31'b0, last_e[k]});
      check($sformatf("%s rsp_data @%0d", nm(k), cyc), rdat[k] & bmask(last_m[k]),
            last_d[k] & bmask(last_m[k]));
    end
  endtask

  // One clock cycle: check outputs, drive the next request, advance the model.
  task automatic step(input logic rst_v, input logic v, input logic w,
                      input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    check_cycle();
    rst_n     = rst_v;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_be    = be;
    req_data  = d;
    if (!rst_v) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (v && clr_left[k] == 0) model_accept(k, w, a, be, d);
      end
      for (int k = 0; k < 2; k++) begin
        if (clr_left[k] > 0) begin
          clr_left[k]--;
          if (clr_left[k] == 0) begin
            for (int i = 0; i < DEPTH; i++) begin
              mem_m[k][i] = 32'h0;
              kn_m[k][i]  = 4'hF;
            end
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b1, a, be, d);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0);
  endtask

  task automatic wait_clear();
    for (int g = 0; g < 40 && clr_left[0] != 0; g++) idle(1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return AW'($urandom_range(0, DEPTH - 1));
    else if (r == 7) return AW'($urandom_range(DEPTH, 2 * DEPTH - 1));
    else if (r == 8) return {AW{1'b1}};
    else             return AW'($urandom);
  endfunction

  initial begin
    logic          v, w;
    logic [31:0]   d;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_data  = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) begin
        mem_m[k][i] = 32'h0;
        kn_m[k][i]  = 4'h0;
      end
    model_reset();

    // Reset, then release with a write held until both instances take it.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    d = 32'hCAFE_0003;
    step(1'b1, 1'b1, 1'b1, AW'(3), 4'hF, d);
    for (int g = 0; g < 40 && clr_left[0] != 0; g++) step(1'b1, 1'b1, 1'b1, AW'(3), 4'hF, d);
    wr(AW'(3), 4'hF, d);
    rd(AW'(3));
    idle(3);

    // Fill with garbage, reset, and read everything back after the sweep.
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 4'hF, $urandom);
    step(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    idle(1);
    wait_clear();
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(3);

    // Byte-lane merge then read-after-write.
    wr(AW'(5), 4'hF, 32'hDEAD_BEEF);
    wr(AW'(5), 4'h5, 32'h1122_3344);
    rd(AW'(5));
    idle(3);

    // Back-to-back writes then back-to-back reads.
    for (int i = 0; i < 4; i++) wr(AW'(i), 4'hF, 32'h10 + 32'(i));
    for (int i = 0; i < 4; i++) rd(AW'(i));
    idle(3);

    // Out-of-range write and read; word 0 must be untouched.
    wr(AW'(16), 4'hF, 32'hBAD0_BAD0);
    rd({AW{1'b1}});
    rd(AW'(0));
    wr(AW'(3), 4'h0, 32'hFFFF_FFFF);
    rd(AW'(3));
    idle(3);

    // Reset with a read in flight, then again halfway through the sweep.
    rd(AW'(1));
    step(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    idle(8);
    step(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    idle(1);
    wait_clear();
    idle(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        w = ($urandom_range(0, 1) != 0);
        step(1'b1, v, w, rand_addr(), 4'($urandom), $urandom);
      end
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory_bank.md
Name: data_memory_bank

Overview:
- Parametrised single-port data memory for the Kabeta data path, replacing the fixed 16 KB wrapper.
- Word-addressed memory with:
  - per-byte write enables
  - valid/ready request handshake
  - selectable 1- or 2-cycle read latency
  - out-of-range detection
  - optional zero-fill sweep after reset
- Sits between the load/store stage and the inferred block RAM. Always-ready response path; no backpressure.

Parameters:
- ADDR_WIDTH, 30, width of the word address input.
- DATA_WIDTH, 32, word width in bits. Must be a multiple of 8. NB = DATA_WIDTH/8 byte lanes.
- DEPTH_WORDS, 4096, number of implemented words. Legal range 2..2^ADDR_WIDTH. IW = clog2(DEPTH_WORDS).
- READ_LATENCY, 1, 1 = RAM output direct; 2 = extra output register. Other values are illegal; elaboration error.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset release; 0 = skip the sweep.

Ports:
- Clock  in  1  rising-edge clock.
- Reset_N  in  1  asynchronous active-low reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  block accepts a request this cycle.
- Req_Write  in  1  1 = write, 0 = read.
- Req_Addr  in  ADDR_WIDTH  word address.
- Req_ByteEn  in  NB  write byte lanes. Lane i covers bits 8i+7:8i. Ignored for reads.
- Req_Data  in  DATA_WIDTH  write data.
- Rsp_Valid  out  1  response strobe, one cycle per response.
- Rsp_Data  out  DATA_WIDTH  read data.
- Rsp_Err  out  1  qualified by Rsp_Valid. 1 = address out of range.

Behaviour:
- Accept: a request is accepted on a rising edge where Req_Valid && Req_Ready. At most one per cycle.
- State machine, two states: CLEAR and RUN.
- Reset (Reset_N low, asynchronous):
  - state = CLEAR if CLEAR_ON_RESET, else RUN
  - clear counter = 0
  - Req_Ready = 0 in CLEAR, 1 in RUN
  - all pipeline valids = 0; Rsp_Valid = 0, Rsp_Err = 0, Rsp_Data = 0
  - memory contents are not reset.
- CLEAR state:
  - Req_Ready = 0.
  - Each edge writes zero to word[counter] and increments the counter.
  - On the edge that writes word DEPTH_WORDS-1, go to RUN. Req_Ready = 1 from the following cycle, i.e. exactly DEPTH_WORDS edges after reset release.
  - Requests presented during CLEAR are not accepted; the requester holds them.
- RUN state: Req_Ready = 1 constantly. Never returns to CLEAR except via reset.
- Range check: in range iff Req_Addr < DEPTH_WORDS. Index = Req_Addr[IW-1:0]; upper bits are used only for the range check.
- Accepted write, in range:
  - Updates the selected byte lanes only, at the accepting edge.
  - Produces no response.
  - Req_ByteEn = 0 is a legal no-op.
- Accepted write, out of range: memory unchanged; one response with Rsp_Err=1 and Rsp_Data=0.
- Accepted read, in range: response with Rsp_Err=0 and the word contents.
- Accepted read, out of range: response with Rsp_Err=1 and Rsp_Data=0; no RAM access.
- Response timing:
  - Rsp_Valid asserts READ_LATENCY cycles after the accepting edge, i.e. after the READ_LATENCY-th subsequent edge, for one cycle.
  - Fully pipelined: back-to-back requests give back-to-back responses in order.
- Rsp_Data and Rsp_Err hold their last values when Rsp_Valid = 0.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data. The write has completed at its accepting edge, so no forwarding is needed.
- Reset asserted mid-operation:
  - In-flight responses are discarded; no Rsp_Valid after reset.
  - A running sweep restarts from word 0.
- The RAM array must infer block RAM:
  - synchronous read
  - byte-write structure
  - no reset on the array
  - the latency-2 register sits outside the array.

Test Plan:
1. Run with DEPTH_WORDS=16, CLEAR_ON_RESET=1. Preload garbage, then release reset -> Req_Ready=0 for 16 edges, 1 thereafter. Reads of addresses 0..15 all return 0x00000000 with Rsp_Err=0.
2. Write 0xDEADBEEF to address 5 with ByteEn=4'b1111. Next cycle write 0x11223344 to address 5 with ByteEn=4'b0101. Then read address 5 -> Rsp_Data=0xDE22BE44, Rsp_Valid exactly 1 cycle after accept (READ_LATENCY=1), or 2 cycles after (READ_LATENCY=2).
3. Continuous reads of addresses 0,1,2,3 on consecutive cycles after writing 0x10,0x11,0x12,0x13 -> Rsp_Valid high 4 consecutive cycles with data 0x10,0x11,0x12,0x13 in order.
4. Write to address 16 (DEPTH_WORDS=16), then read address 0x3FFFFFFF -> two responses, each with Rsp_Err=1 and Rsp_Data=0. Word 0 is unchanged (aliasing check).
5. Assert Reset_N low for 1 cycle while a read is in flight and the sweep is half done -> no Rsp_Valid appears. Req_Ready stays 0 for a full 16 edges after release.
6. Run with CLEAR_ON_RESET=0 -> Req_Ready=1 in the first cycle after reset release. A request accepted on the first edge is serviced normally.
